// File: rtl/cu_ws.sv
// cu_ws: multi-cycle control unit for the 8-instruction accumulator CPU.
// It decodes opcode IR[7:5] and drives the PC, IR, accumulator and memory strobes.
// Parameters:
//   MEM_WAIT   - extra wait cycles in each memory-access state (0..15).
//   ENTER_EDGE - INPUT completes on an Enter level (0) or a rising edge (1).
// Optional single-step gate on START: define CU_STEP_EN.
// Ports:
//   Clock, Reset (sync, active high)
//   Enter, Step, IR[2:0], Aeq0, Apos
//   IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt, Asel[1:0]
//   CheckState[3:0]
module cu_ws #(
    parameter int MEM_WAIT   = 0,
    parameter int ENTER_EDGE = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enter,
    input  logic       Step,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic       Halt,
    output logic [1:0] Asel,
    output logic [3:0] CheckState
);

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       enter_prev_q, enter_prev_d;

    logic       last_cyc;
    logic       enter_ok;

    // Non-final stretch cycles count up; any transition clears the counter.
    assign last_cyc = (cnt_q == 4'(MEM_WAIT));

    generate
        if (ENTER_EDGE != 0) begin : g_edge
            assign enter_ok = Enter & ~enter_prev_q;
        end else begin : g_level
            assign enter_ok = Enter;
        end
    endgenerate

`ifndef CU_STEP_EN
    logic unused_step;
    assign unused_step = Step;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = 4'd0;
        enter_prev_d = Enter;
        IRload       = 1'b0;
        JMPmux       = 1'b0;
        PCload       = 1'b0;
        Meminst      = 1'b0;
        MemWr        = 1'b0;
        Aload        = 1'b0;
        Sub          = 1'b0;
        Halt         = 1'b0;
        Asel         = 2'b00;

        case (state_q)
            S_START: begin
`ifdef CU_STEP_EN
                state_d = Step ? S_FETCH : S_START;
`else
                state_d = S_FETCH;
`endif
            end
            S_FETCH: begin
                IRload = last_cyc;
                PCload = last_cyc;
            end
            S_DECODE: begin
                Meminst = 1'b1;
                case (IR)
                    3'b000:  state_d = S_LOAD;
                    3'b001:  state_d = S_STORE;
                    3'b010:  state_d = S_ADD;
                    3'b011:  state_d = S_SUB;
                    3'b100:  state_d = S_INPUT;
                    3'b101:  state_d = S_JZ;
                    3'b110:  state_d = S_JPOS;
                    default: state_d = S_HALT;
                endcase
            end
            S_LOAD: begin
                Meminst = 1'b1;
                Asel    = 2'b10;
                Aload   = last_cyc;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = last_cyc;
            end
            S_ADD: begin
                Meminst = 1'b1;
                Aload   = last_cyc;
            end
            S_SUB: begin
                Meminst = 1'b1;
                Sub     = 1'b1;
                Aload   = last_cyc;
            end
            S_INPUT: begin
                Asel  = 2'b01;
                Aload = enter_ok;
                if (enter_ok) state_d = S_START;
            end
            S_JZ: begin
                JMPmux  = 1'b1;
                PCload  = Aeq0;
                state_d = S_START;
            end
            S_JPOS: begin
                JMPmux  = 1'b1;
                PCload  = Apos;
                state_d = S_START;
            end
            S_HALT: begin
                Halt = 1'b1;
            end
            default: state_d = S_START;
        endcase

        // Stretched states either advance on the final cycle or keep counting.
        case (state_q)
            S_FETCH, S_LOAD, S_STORE, S_ADD, S_SUB: begin
                if (last_cyc) begin
                    state_d = (state_q == S_FETCH) ? S_DECODE : S_START;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase

        // A reset cycle never issues a strobe, so aborted work leaves no trace.
        if (Reset) begin
            IRload = 1'b0;
            PCload = 1'b0;
            MemWr  = 1'b0;
            Aload  = 1'b0;
            Halt   = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_START;
            cnt_q        <= 4'd0;
            enter_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            enter_prev_q <= enter_prev_d;
        end
    end

    assign CheckState = state_q;

endmodule

// File: tb/tb_cu_ws.sv
// tb_cu_ws: directed self-checking bench for cu_ws.
// Three instances cover MEM_WAIT 0/2/3 and both Enter modes.
module tb_cu_ws;

    logic       Clock = 1'b0;
    logic       r0, r1, r3;
    logic       Enter, Step, Aeq0, Apos;
    logic [2:0] IR;

    logic       irl0, jmx0, pcl0, mi0, mw0, al0, sb0, hl0;
    logic [1:0] as0;
    logic [3:0] cs0;
    logic       irl1, jmx1, pcl1, mi1, mw1, al1, sb1, hl1;
    logic [1:0] as1;
    logic [3:0] cs1;
    logic       irl3, jmx3, pcl3, mi3, mw3, al3, sb3, hl3;
    logic [1:0] as3;
    logic [3:0] cs3;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    cu_ws #(.MEM_WAIT(0), .ENTER_EDGE(0)) u0 (
        .Clock(Clock), .Reset(r0), .Enter(Enter), .Step(Step), .IR(IR),
        .Aeq0(Aeq0), .Apos(Apos), .IRload(irl0), .JMPmux(jmx0),
        .PCload(pcl0), .Meminst(mi0), .MemWr(mw0), .Aload(al0),
        .Sub(sb0), .Halt(hl0), .Asel(as0), .CheckState(cs0)
    );

    cu_ws #(.MEM_WAIT(2), .ENTER_EDGE(1)) u1 (
        .Clock(Clock), .Reset(r1), .Enter(Enter), .Step(Step), .IR(IR),
        .Aeq0(Aeq0), .Apos(Apos), .IRload(irl1), .JMPmux(jmx1),
        .PCload(pcl1), .Meminst(mi1), .MemWr(mw1), .Aload(al1),
        .Sub(sb1), .Halt(hl1), .Asel(as1), .CheckState(cs1)
    );

    cu_ws #(.MEM_WAIT(3), .ENTER_EDGE(1)) u3 (
        .Clock(Clock), .Reset(r3), .Enter(Enter), .Step(Step), .IR(IR),
        .Aeq0(Aeq0), .Apos(Apos), .IRload(irl3), .JMPmux(jmx3),
        .PCload(pcl3), .Meminst(mi3), .MemWr(mw3), .Aload(al3),
        .Sub(sb3), .Halt(hl3), .Asel(as3), .CheckState(cs3)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        r0 = 1; r1 = 1; r3 = 1;
        Enter = 0; Step = 1; Aeq0 = 0; Apos = 0; IR = 3'b000;
        tick();
        chk("rst_cs0", 8'(cs0), 8'd0);
        chk("rst_strobes0", {irl0, pcl0, mw0, al0, hl0}, 8'd0);
        chk("rst_cs1", 8'(cs1), 8'd0);

        // LOAD, no waits
        r0 = 0; #1;
        chk("ld_start", 8'(cs0), 8'd0);
        tick();
        chk("ld_fetch", 8'(cs0), 8'd1);
        chk("ld_fetch_str", {irl0, pcl0, jmx0, mi0}, 8'b1100);
        tick();
        chk("ld_dec", 8'(cs0), 8'd2);
        chk("ld_dec_mi", 8'(mi0), 8'd1);
        tick();
        chk("ld_exec", 8'(cs0), 8'd3);
        chk("ld_exec_str", {al0, as0, mi0}, 8'b1101);
        tick();
        chk("ld_done", 8'(cs0), 8'd0);

        // JZ taken, then not taken in the same cycle (Mealy)
        IR = 3'b101; Aeq0 = 1;
        tick(3);
        chk("jz_cs", 8'(cs0), 8'd8);
        chk("jz_taken", {pcl0, jmx0}, 8'b11);
        Aeq0 = 0; #1;
        chk("jz_not", {pcl0, jmx0}, 8'b01);
        tick();
        chk("jz_done", 8'(cs0), 8'd0);

        // JPOS taken
        IR = 3'b110; Apos = 1;
        tick(3);
        chk("jpos_cs", 8'(cs0), 8'd9);
        chk("jpos_taken", {pcl0, jmx0}, 8'b11);
        Apos = 0;
        tick();
        chk("jpos_done", 8'(cs0), 8'd0);

        // INPUT, level mode
        IR = 3'b100; Enter = 0;
        tick(3);
        chk("in_cs", 8'(cs0), 8'd7);
        chk("in_wait", {al0, as0}, 8'b001);
        tick();
        chk("in_hold", 8'(cs0), 8'd7);
        Enter = 1; #1;
        chk("in_lvl_al", 8'(al0), 8'd1);
        tick();
        chk("in_done", 8'(cs0), 8'd0);
        Enter = 0;

        // HALT is absorbing; Reset masks Halt and exits
        IR = 3'b111;
        tick(3);
        chk("halt_cs", 8'(cs0), 8'd10);
        chk("halt_out", 8'(hl0), 8'd1);
        tick(22);
        chk("halt_held", {cs0, 3'b000, hl0}, 8'hA1);
        r0 = 1; #1;
        chk("halt_rst_mask", 8'(hl0), 8'd0);
        tick();
        chk("halt_rst_cs", 8'(cs0), 8'd0);

        // STORE with MEM_WAIT=2
        IR = 3'b001; r1 = 0;
        tick();
        chk("st_f0", {cs1, irl1, pcl1}, {4'd1, 2'b00});
        tick();
        chk("st_f1", {cs1, irl1, pcl1}, {4'd1, 2'b00});
        tick();
        chk("st_f2", {cs1, irl1, pcl1}, {4'd1, 2'b11});
        tick();
        chk("st_dec", 8'(cs1), 8'd2);
        tick();
        chk("st_s0", {cs1, mw1, mi1}, {4'd4, 2'b01});
        tick();
        chk("st_s1", {cs1, mw1, mi1}, {4'd4, 2'b01});
        tick();
        chk("st_s2", {cs1, mw1, mi1}, {4'd4, 2'b11});
        tick();
        chk("st_done", {cs1, mw1}, {4'd0, 1'b0});

        // INPUT, edge mode with Enter already high
        IR = 3'b100; Enter = 1;
        tick(5);
        chk("ie_cs", 8'(cs1), 8'd7);
        chk("ie_held_al", 8'(al1), 8'd0);
        tick();
        chk("ie_hold", {cs1, al1}, {4'd7, 1'b0});
        Enter = 0;
        tick();
        chk("ie_low", {cs1, al1}, {4'd7, 1'b0});
        Enter = 1; #1;
        chk("ie_rise", 8'(al1), 8'd1);
        tick();
        chk("ie_done", {cs1, al1}, {4'd0, 1'b0});
        Enter = 0;
        r1 = 1;

        // SUB with MEM_WAIT=3
        IR = 3'b011; r3 = 0;
        tick(6);
        chk("sub_s0", {cs3, sb3, al3, mi3}, {1'b0, 4'd6, 3'b101});
        tick(3);
        chk("sub_s3", {cs3, sb3, al3, as3}, {4'd6, 4'b1100});
        tick();
        chk("sub_done", 8'(cs3), 8'd0);

        // Reset in the final ADD cycle suppresses Aload
        IR = 3'b010;
        tick(6);
        chk("add_s0", {cs3, sb3, al3, mi3}, {1'b0, 4'd5, 3'b001});
        tick(2);
        chk("add_s2", {cs3, al3}, {4'd5, 1'b0});
        tick();
        chk("add_s3_al", 8'(al3), 8'd1);
        r3 = 1; #1;
        chk("add_rst_al", 8'(al3), 8'd0);
        tick();
        chk("add_rst_cs", 8'(cs3), 8'd0);

`ifdef CU_STEP_EN
        // Step gate: one pulse runs one LOAD
        IR = 3'b000; Step = 0; r0 = 0;
        tick(3);
        chk("step_idle", 8'(cs0), 8'd0);
        Step = 1;
        tick();
        Step = 0; #1;
        chk("step_fetch", 8'(cs0), 8'd1);
        tick(2);
        chk("step_exec", 8'(cs0), 8'd3);
        tick();
        chk("step_back", 8'(cs0), 8'd0);
        tick(2);
        chk("step_stay", 8'(cs0), 8'd0);
`else
        // Step ignored: START advances with Step low
        IR = 3'b000; Step = 0; r0 = 0;
        tick();
        chk("nostep_fetch", 8'(cs0), 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_ws.md
# cu_ws

Parametrised multi-cycle control unit for the 8-instruction accumulator CPU. It is the next-generation successor to the fixed-timing control unit. It decodes the 3-bit opcode from IR[7:5] and drives the PC, IR, accumulator and memory strobes. It adds configurable memory wait states, a selectable Enter handshake, and an optional single-step gate. It sits between the instruction register/status flags and the datapath mux/load controls.

## Interface
- MEM_WAIT, 0: extra wait cycles for each memory-access state (legal range 0..15).
- ENTER_EDGE, 0: INPUT completion mode. 0 = Enter level high; 1 = Enter rising edge (Enter=1 while the registered previous Enter=0).
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enter  in  1  operator input-ready.
- Step  in  1  single-step request; used only with CU_STEP_EN.
- IR  in  3  opcode field IR[7:5].
- Aeq0  in  1  accumulator equals zero.
- Apos  in  1  accumulator positive.
- IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt  out  1 each  datapath strobes/selects.
- Asel  out  2  accumulator source: 00 adder, 01 input, 10 memory.
- CheckState  out  4  current state encoding.

## Operation
- State encodings:
  - 0 START, 1 FETCH, 2 DECODE, 3 LOAD, 4 STORE, 5 ADD, 6 SUB.
  - 7 INPUT, 8 JZ, 9 JPOS, 10 HALT; 11–15 unused, recover to START.
- Outputs are combinational from state, wait counter and inputs. Any output not listed for a state is 0.
- START: no strobes. Goes to FETCH.
- FETCH: Meminst=0. IRload=1 and PCload=1 (JMPmux=0, PC+1) only in the final cycle. Goes to DECODE.
- DECODE: Meminst=1. Next state by opcode:
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB.
  - 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
- LOAD: Meminst=1, Asel=10; Aload=1 in the final cycle.
- STORE: Meminst=1; MemWr=1 in the final cycle only.
- ADD: Meminst=1, Asel=00, Sub=0; Aload=1 in the final cycle.
- SUB: Meminst=1, Asel=00, Sub=1; Aload=1 in the final cycle.
- INPUT: Asel=01. Holds until the Enter condition is met. In that cycle Aload=1, then goes to START.
- JZ: JMPmux=1, PCload=Aeq0, one cycle. JPOS: JMPmux=1, PCload=Apos, one cycle.
- HALT: Halt=1. Absorbing; only Reset exits.
- Every execute state except HALT returns to START.
- Stretched states are FETCH, LOAD, STORE, ADD and SUB.
  - Each lasts MEM_WAIT+1 cycles, tracked by a 4-bit counter that is cleared on entry.
  - Address select and Asel/Sub are held for the whole state; load/write strobes fire only when counter==MEM_WAIT.
- The registered previous Enter updates every cycle, in all states.

## Timing
- Reset sampled high sets state START, clears the wait counter and clears the previous-Enter register on that edge.
- While Reset=1, all strobe outputs (IRload, PCload, MemWr, Aload, Halt) are forced to 0, regardless of state.
- Reset mid-stretch or mid-INPUT aborts the instruction; no partial strobe is issued.
- Instruction cycle counts with MEM_WAIT=0:
  - LOAD, STORE, ADD, SUB: 4 cycles each (START, FETCH, DECODE, exec).
  - JZ, JPOS: 4 cycles.
  - INPUT: 4 cycles plus Enter wait.
- Each stretched state adds MEM_WAIT cycles.
- ENTER_EDGE=1: Enter already held high on entry to INPUT does not complete it; a fresh 0→1 transition is required.
- PCload in JZ/JPOS and Aload in INPUT follow their inputs in the same cycle (Mealy).

## Configuration
- CU_STEP_EN defined: START holds, with no strobes, until Step=1 is sampled. It then goes to FETCH. This gives one instruction per Step pulse; Step held high free-runs.
- CU_STEP_EN undefined: Step is ignored and START always advances to FETCH after one cycle.

## Test plan
- LOAD, MEM_WAIT=0: Reset, then IR=000. Expect CheckState 0,1,2,3, then 0. Expect IRload/PCload high in cycle 2 and Aload=1 with Asel=10 in cycle 4.
- MEM_WAIT=2, IR=001 (STORE): FETCH lasts 3 cycles with IRload high only in the 3rd. STORE lasts 3 cycles with MemWr high exactly one cycle, in the 3rd.
- JZ/JPOS: IR=101 with Aeq0=1 gives PCload=1, JMPmux=1. IR=101 with Aeq0=0 gives PCload=0. IR=110 with Apos=1 gives PCload=1.
- INPUT with ENTER_EDGE=1: Enter held 1 on entry leaves state 7 held and Aload=0. Enter 0 then 1 gives Aload=1 for one cycle, then START.
- HALT and Reset: IR=111 gives Halt=1 held for 20+ cycles. Reset asserted mid-ADD stretch (MEM_WAIT=3) gives no Aload, and CheckState=0 on the next edge.
- CU_STEP_EN defined, Step=0: FSM stays in START. A one-cycle Step pulse executes exactly one instruction and the FSM returns to START.
